// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters with sync, blanking and
// frame-start strobes all registered in the same cycle as the counters.
module vga_timing #(
    parameter int unsigned HOR_TOTAL      = 1056,
    parameter int unsigned HOR_ACTIVE     = 800,
    parameter int unsigned HOR_SYNC_START = 840,
    parameter int unsigned HOR_SYNC_STOP  = 968,
    parameter int unsigned VER_TOTAL      = 628,
    parameter int unsigned VER_ACTIVE     = 600,
    parameter int unsigned VER_SYNC_START = 601,
    parameter int unsigned VER_SYNC_STOP  = 605,
    parameter bit          SYNC_POL       = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
    output logic        vblnk,
    output logic        frame_start
);

    localparam int unsigned CW = 11;
    // One extra bit so a SYNC_STOP of 2048 still compares correctly.
    localparam int unsigned XW = CW + 1;

    localparam logic [CW-1:0] H_LAST = CW'(HOR_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(VER_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT  = XW'(HOR_ACTIVE);
    localparam logic [XW-1:0] H_SS   = XW'(HOR_SYNC_START);
    localparam logic [XW-1:0] H_SE   = XW'(HOR_SYNC_STOP);
    localparam logic [XW-1:0] V_ACT  = XW'(VER_ACTIVE);
    localparam logic [XW-1:0] V_SS   = XW'(VER_SYNC_START);
    localparam logic [XW-1:0] V_SE   = XW'(VER_SYNC_STOP);

    logic [CW-1:0] hcount_q, hcount_d;
    logic [CW-1:0] vcount_q, vcount_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          hblnk_q, hblnk_d;
    logic          vblnk_q, vblnk_d;
    logic          frame_start_q, frame_start_d;
    logic [XW-1:0] hx, vx;

    // Next counter values; decodes use them so flags line up with the counters.
    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_start_d = 1'b0;
        if (ce) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                if (vcount_q == V_LAST) begin
                    vcount_d      = '0;
                    frame_start_d = 1'b1;
                end else begin
                    vcount_d = vcount_q + CW'(1);
                end
            end else begin
                hcount_d = hcount_q + CW'(1);
            end
        end

        hx      = {1'b0, hcount_d};
        vx      = {1'b0, vcount_d};
        hblnk_d = (hx >= H_ACT);
        vblnk_d = (vx >= V_ACT);
        hsync_d = ((hx >= H_SS) && (hx < H_SE)) ? SYNC_POL : ~SYNC_POL;
        vsync_d = ((vx >= V_SS) && (vx < V_SE)) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hblnk       = hblnk_q;
    assign vblnk       = vblnk_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: two small-geometry instances (both sync polarities)
// compared every cycle against an enabled-cycle-count arithmetic model.
module tb_vga_timing;

    localparam int unsigned HT1 = 20, HA1 = 12, HSS1 = 14, HSE1 = 17;
    localparam int unsigned VT1 = 10, VA1 = 6,  VSS1 = 7,  VSE1 = 9;
    localparam int unsigned HT2 = 16, HA2 = 10, HSS2 = 11, HSE2 = 16;
    localparam int unsigned VT2 = 8,  VA2 = 5,  VSS2 = 6,  VSE2 = 8;
    localparam int unsigned P1  = HT1 * VT1;
    localparam int unsigned P2  = HT2 * VT2;

    logic        clk, rst_n, ce;
    logic [10:0] hcount1, vcount1, hcount2, vcount2;
    logic        hsync1, vsync1, hblnk1, vblnk1, fs1;
    logic        hsync2, vsync2, hblnk2, vblnk2, fs2;

    int unsigned n_checks, n_pass;
    int unsigned n;          // enabled edges since reset release
    bit          last_en;    // previous edge advanced the counters
    bit          seen;
    int unsigned cyc_since, en_since, expect_clk;

    vga_timing #(
        .HOR_TOTAL(HT1), .HOR_ACTIVE(HA1), .HOR_SYNC_START(HSS1), .HOR_SYNC_STOP(HSE1),
        .VER_TOTAL(VT1), .VER_ACTIVE(VA1), .VER_SYNC_START(VSS1), .VER_SYNC_STOP(VSE1),
        .SYNC_POL(1'b1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .hcount(hcount1), .vcount(vcount1), .hsync(hsync1), .vsync(vsync1),
        .hblnk(hblnk1), .vblnk(vblnk1), .frame_start(fs1)
    );

    vga_timing #(
        .HOR_TOTAL(HT2), .HOR_ACTIVE(HA2), .HOR_SYNC_START(HSS2), .HOR_SYNC_STOP(HSE2),
        .VER_TOTAL(VT2), .VER_ACTIVE(VA2), .VER_SYNC_START(VSS2), .VER_SYNC_STOP(VSE2),
        .SYNC_POL(1'b0)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .hcount(hcount2), .vcount(vcount2), .hsync(hsync2), .vsync(vsync2),
        .hblnk(hblnk2), .vblnk(vblnk2), .frame_start(fs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Raster position is a pure function of how many enabled edges have elapsed.
    function automatic logic [25:0] model(input int unsigned cnt,
                                          input int unsigned ht, ha, hss, hse,
                                          input int unsigned vt, va, vss, vse,
                                          input bit pol);
        int unsigned h, v;
        logic hs, vs;
        h  = cnt % ht;
        v  = (cnt / ht) % vt;
        hs = (h >= hss && h < hse) ? pol : ~pol;
        vs = (v >= vss && v < vse) ? pol : ~pol;
        return {11'(h), 11'(v), hs, vs, 1'(h >= ha), 1'(v >= va)};
    endfunction

    task automatic check_dut(input string pfx, input logic [25:0] got, input logic [25:0] exp,
                             input logic fs_got, input logic fs_exp);
        chk({pfx, "_hcount"}, 32'(got[25:15]), 32'(exp[25:15]));
        chk({pfx, "_vcount"}, 32'(got[14:4]),  32'(exp[14:4]));
        chk({pfx, "_hsync"},  32'(got[3]),     32'(exp[3]));
        chk({pfx, "_vsync"},  32'(got[2]),     32'(exp[2]));
        chk({pfx, "_hblnk"},  32'(got[1]),     32'(exp[1]));
        chk({pfx, "_vblnk"},  32'(got[0]),     32'(exp[0]));
        chk({pfx, "_frame_start"}, 32'(fs_got), 32'(fs_exp));
    endtask

    task automatic check_all();
        logic [25:0] e1, e2;
        e1 = model(n, HT1, HA1, HSS1, HSE1, VT1, VA1, VSS1, VSE1, 1'b1);
        e2 = model(n, HT2, HA2, HSS2, HSE2, VT2, VA2, VSS2, VSE2, 1'b0);
        check_dut("d1", {hcount1, vcount1, hsync1, vsync1, hblnk1, vblnk1}, e1,
                  fs1, 1'(last_en && n != 0 && (n % P1) == 0));
        check_dut("d2", {hcount2, vcount2, hsync2, vsync2, hblnk2, vblnk2}, e2,
                  fs2, 1'(last_en && n != 0 && (n % P2) == 0));
    endtask

    // Called at a falling edge: drive inputs, take one rising edge, check at the next fall.
    task automatic step(input bit ce_v, input bit rst_v);
        ce    = ce_v;
        rst_n = rst_v;
        if (!rst_v) begin
            n       = 0;
            last_en = 1'b0;
            seen    = 1'b0;
            #1;
            check_all();
        end
        @(posedge clk);
        if (rst_n && ce) begin
            n++;
            last_en = 1'b1;
            en_since++;
        end else begin
            last_en = 1'b0;
        end
        cyc_since++;
        @(negedge clk);
        check_all();
        if (fs1) begin
            if (seen) begin
                chk("period_enabled", en_since, P1);
                if (expect_clk != 0) chk("period_clk", cyc_since, expect_clk);
            end
            seen      = 1'b1;
            en_since  = 0;
            cyc_since = 0;
        end
    endtask

    initial begin
        bit found;
        n_checks = 0; n_pass = 0;
        n = 0; last_en = 1'b0; seen = 1'b0;
        cyc_since = 0; en_since = 0; expect_clk = 0;
        rst_n = 1'b0;
        ce    = 1'b0;
        repeat (3) @(negedge clk);
        check_all();

        // Free-running, two full frames plus margin; no pulse on reset exit.
        expect_clk = P1;
        repeat (2 * P1 + 50) step(1'b1, 1'b1);

        // ce toggling every cycle doubles the frame period in clocks.
        seen = 1'b0;
        expect_clk = 2 * P1;
        for (int i = 0; i < 5 * P1; i++) step(1'(i % 2 == 0), 1'b1);
        expect_clk = 0;

        // Mid-frame asynchronous reset, then restart from hcount=1 on the first edge.
        found = 1'b0;
        for (int i = 0; i < 2 * P1 && !found; i++) begin
            step(1'b1, 1'b1);
            found = (hcount1 == 11'd10 && vcount1 == 11'd5);
        end
        chk("reach_mid_frame", 32'(found), 32'd1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("rst_exit_hcount", 32'(hcount1), 32'd1);
        chk("rst_exit_vcount", 32'(vcount1), 32'd0);

        // Random ce with occasional asynchronous resets.
        seen = 1'b0;
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 299) != 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
